// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising experiment instruction path.
package ising_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWaitClr
  } seq_state_t;

  // Bit positions of the control fields inside one instruction word.
  localparam int unsigned REM_A     = 0;
  localparam int unsigned REM_B     = 1;
  localparam int unsigned REM_C     = 2;
  localparam int unsigned OUT_TO_A  = 3;
  localparam int unsigned OUT_TO_C  = 4;
  localparam int unsigned ZERO_TO_A = 5;
  localparam int unsigned ZERO_TO_C = 6;
  localparam int unsigned SWITCH    = 7;

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port program memory: one write port, one registered read port (BRAM style).
module instr_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Stores the CPU-written instruction program and replays it as an AXI-stream for a
// programmable number of rounds, through a 2-entry prefetch buffer.
module instr_sequencer
  import ising_pkg::*;
#(
  parameter int unsigned INSTR_W = ising_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] ld_tdata,
  input  logic               ld_tvalid,
  output logic               ld_tready,
  input  logic               prog_clear,
  input  logic [CNT_W-1:0]   num_rounds,
  input  logic               run_trig,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_tdata,
  output logic               instr_tvalid,
  input  logic               instr_tready,
  output logic               instr_tlast,
  output logic               busy,
  output logic               run_done,
  output logic               aborted,
  output logic [CNT_W-1:0]   round_cnt,
  output logic [CNT_W-1:0]   prog_len,
  output logic               err_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);
  localparam logic [AW-1:0]    OneA   = AW'(1);

  seq_state_t state_q, state_d;
  logic trig_q, rdy_q;
  logic [CNT_W-1:0] prog_len_q, prog_len_d, rounds_q, rounds_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d, issue_rnd_q, issue_rnd_d;
  logic err_ovf_q, err_ovf_d, aborted_q, aborted_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic pend_q, pend_d, pend_last_q, pend_last_d;
  logic [INSTR_W:0] fifo_q [2];
  logic [INSTR_W:0] fifo_d [2];
  logic [1:0] cnt_q, cnt_d, occ_next;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [INSTR_W-1:0] ram_rdata;
  logic [INSTR_W:0] head;
  logic trig_edge, ld_fire, ram_we, rd_en, rd_is_last, xfer;

  instr_ram #(
    .WIDTH(INSTR_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_instr_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(prog_len_q[AW-1:0]),
    .wdata(ld_tdata),
    .re   (rd_en),
    .raddr(rd_addr_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    trig_edge    = run_trig & ~trig_q;
    ld_tready    = rdy_q & (state_q == StIdle);
    ld_fire      = ld_tvalid & ld_tready;
    ram_we       = ld_fire & ~prog_clear & (prog_len_q != DepthC);
    head         = fifo_q[rd_ptr_q];
    instr_tvalid = (state_q == StRun) & (cnt_q != 2'd0);
    instr_tdata  = head[INSTR_W-1:0];
    instr_tlast  = head[INSTR_W];
    xfer         = instr_tvalid & instr_tready;
    rd_is_last   = (CNT_W'(rd_addr_q) == prog_len_q - OneC);
    // Buffered words plus the read landing this cycle, minus the word leaving now.
    occ_next     = cnt_q + {1'b0, pend_q} - {1'b0, xfer};
    rd_en        = (state_q == StRun) & ~abort & (issue_rnd_q != rounds_q) & (occ_next < 2'd2);
    busy         = (state_q == StRun);
    run_done     = (state_q == StWaitClr);
    aborted      = aborted_q;
    round_cnt    = round_cnt_q;
    prog_len     = prog_len_q;
    err_ovf      = err_ovf_q;
  end

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    err_ovf_d   = err_ovf_q;
    rounds_d    = rounds_q;
    round_cnt_d = round_cnt_q;
    issue_rnd_d = issue_rnd_q;
    aborted_d   = aborted_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = rd_en;
    pend_last_d = rd_is_last;
    fifo_d      = fifo_q;
    cnt_d       = occ_next;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (rd_en) begin
      if (rd_is_last) begin
        rd_addr_d   = '0;
        issue_rnd_d = issue_rnd_q + OneC;
      end else begin
        rd_addr_d = rd_addr_q + OneA;
      end
    end
    if (pend_q) begin
      fifo_d[wr_ptr_q] = {pend_last_q, ram_rdata};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (xfer) begin
      rd_ptr_d = ~rd_ptr_q;
      if (instr_tlast) begin
        round_cnt_d = round_cnt_q + OneC;
      end
    end

    if (prog_clear && state_q != StRun) begin
      prog_len_d = '0;
      err_ovf_d  = 1'b0;
    end else if (ld_fire) begin
      if (prog_len_q == DepthC) begin
        err_ovf_d = 1'b1;
      end else begin
        prog_len_d = prog_len_q + OneC;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (trig_edge) begin
          rounds_d    = num_rounds;
          round_cnt_d = '0;
          aborted_d   = 1'b0;
          rd_addr_d   = '0;
          issue_rnd_d = '0;
          pend_d      = 1'b0;
          cnt_d       = 2'd0;
          wr_ptr_d    = 1'b0;
          rd_ptr_d    = 1'b0;
          state_d     = (prog_len_q == '0 || num_rounds == '0) ? StWaitClr : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          aborted_d = 1'b1;
          pend_d    = 1'b0;
          cnt_d     = 2'd0;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
          state_d   = StWaitClr;
        end else if (xfer && instr_tlast && (round_cnt_q + OneC == rounds_q)) begin
          state_d = StWaitClr;
        end
      end
      StWaitClr: begin
        if (!run_trig) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      rdy_q       <= 1'b0;
      prog_len_q  <= '0;
      err_ovf_q   <= 1'b0;
      rounds_q    <= '0;
      round_cnt_q <= '0;
      issue_rnd_q <= '0;
      aborted_q   <= 1'b0;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= run_trig;
      rdy_q       <= 1'b1;
      prog_len_q  <= prog_len_d;
      err_ovf_q   <= err_ovf_d;
      rounds_q    <= rounds_d;
      round_cnt_q <= round_cnt_d;
      issue_rnd_q <= issue_rnd_d;
      aborted_q   <= aborted_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: load, replay, stall, empty runs, overflow, abort, reset.
module tb_instr_sequencer;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [INSTR_W-1:0] ld_tdata = '0;
  logic ld_tvalid = 1'b0, ld_tready;
  logic prog_clear = 1'b0;
  logic [CNT_W-1:0] num_rounds = '0;
  logic run_trig = 1'b0, abort = 1'b0;
  logic [INSTR_W-1:0] instr_tdata;
  logic instr_tvalid, instr_tlast;
  logic instr_tready = 1'b0;
  logic busy, run_done, aborted, err_ovf;
  logic [CNT_W-1:0] round_cnt, prog_len;

  int n_tests = 0;
  int n_fail  = 0;
  logic [INSTR_W-1:0] prog_w [4] = '{16'h0001, 16'h0009, 16'h0012, 16'h0080};

  instr_sequencer #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_tdata    (ld_tdata),
    .ld_tvalid   (ld_tvalid),
    .ld_tready   (ld_tready),
    .prog_clear  (prog_clear),
    .num_rounds  (num_rounds),
    .run_trig    (run_trig),
    .abort       (abort),
    .instr_tdata (instr_tdata),
    .instr_tvalid(instr_tvalid),
    .instr_tready(instr_tready),
    .instr_tlast (instr_tlast),
    .busy        (busy),
    .run_done    (run_done),
    .aborted     (aborted),
    .round_cnt   (round_cnt),
    .prog_len    (prog_len),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_word(input logic [INSTR_W-1:0] w);
    @(negedge clk);
    ld_tdata  = w;
    ld_tvalid = 1'b1;
    @(negedge clk);
    ld_tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
  endtask

  task automatic end_run();
    @(negedge clk);
    run_trig     = 1'b0;
    instr_tready = 1'b0;
    @(negedge clk);
    check("idle_done", run_done, 0);
    check("idle_busy", busy, 0);
    check("idle_ld_tready", ld_tready, 1);
  endtask

  // Plays one run; k counts negedges after the edge-sampling posedge (k=0 right after it).
  task automatic run_prog(input int rounds, input bit rnd, input int abort_at, output int nx,
                          output int first_k, output int last_k, output int done_k);
    logic hold, abort_chk;
    logic [INSTR_W:0] held;
    nx = 0; first_k = -1; last_k = -1; done_k = -1;
    hold = 1'b0; abort_chk = 1'b0; held = '0;
    @(negedge clk);
    num_rounds = CNT_W'(rounds);
    run_trig   = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (abort_chk) begin
        check("abort_tvalid", instr_tvalid, 0);
        check("abort_flag", aborted, 1);
        abort     = 1'b0;
        abort_chk = 1'b0;
      end
      if (hold) check("stall_hold", {instr_tvalid, instr_tlast, instr_tdata}, {1'b1, held});
      if (run_done) begin
        done_k = k;
        break;
      end
      instr_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at > 0 && nx == abort_at - 1 && instr_tvalid) begin
        abort        = 1'b1;
        instr_tready = 1'b1;
        abort_chk    = 1'b1;
      end
      hold = instr_tvalid & ~instr_tready;
      held = {instr_tlast, instr_tdata};
      if (instr_tvalid && instr_tready) begin
        check("data", instr_tdata, prog_w[nx % 4]);
        check("tlast", instr_tlast, (nx % 4) == 3);
        if (first_k < 0) first_k = k;
        last_k = k;
        nx++;
      end
    end
    if (done_k < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx, fk, lk, dk;

    // Reset state
    #12;
    check("rst_ld_tready", ld_tready, 0);
    check("rst_outputs", {instr_tvalid, instr_tlast, busy, run_done, aborted, err_ovf}, 0);
    check("rst_counts", {round_cnt, prog_len}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ld_tready", ld_tready, 1);

    // Nominal 4-word, 3-round run
    for (int i = 0; i < 4; i++) load_word(prog_w[i]);
    check("prog_len4", prog_len, 4);
    run_prog(3, 1'b0, 0, nx, fk, lk, dk);
    check("n_xfer", nx, 12);
    check("first_valid_k", fk, 2);
    check("back_to_back", lk - fk, 11);
    check("done_latency", dk, lk + 1);
    check("round_cnt3", round_cnt, 3);
    check("busy_done", busy, 0);
    end_run();

    // Same program with random backpressure
    run_prog(3, 1'b1, 0, nx, fk, lk, dk);
    check("rnd_n_xfer", nx, 12);
    check("rnd_round_cnt", round_cnt, 3);
    check("rnd_done_latency", dk, lk + 1);
    end_run();

    // num_rounds = 0
    run_prog(0, 1'b0, 0, nx, fk, lk, dk);
    check("zero_rounds_xfer", nx, 0);
    check("zero_rounds_done_k", dk, 0);
    end_run();

    // prog_len = 0
    pulse_clear();
    check("clear_len", prog_len, 0);
    run_prog(2, 1'b0, 0, nx, fk, lk, dk);
    check("empty_xfer", nx, 0);
    check("empty_done_k", dk, 0);
    end_run();

    // Overflow: DEPTH + 2 writes
    for (int i = 0; i < DEPTH; i++) load_word(INSTR_W'(i));
    check("full_len", prog_len, DEPTH);
    check("full_no_ovf", err_ovf, 0);
    load_word(16'hdead);
    load_word(16'hbeef);
    check("ovf_len", prog_len, DEPTH);
    check("ovf_flag", err_ovf, 1);
    pulse_clear();
    check("ovf_clear_len", prog_len, 0);
    check("ovf_clear_flag", err_ovf, 0);

    // Abort at word 6 of a 4-word x 5-round run
    for (int i = 0; i < 4; i++) load_word(prog_w[i]);
    run_prog(5, 1'b0, 6, nx, fk, lk, dk);
    check("abort_xfer", nx, 6);
    check("abort_round_cnt", round_cnt, 1);
    check("abort_done_k", dk, lk + 1);
    end_run();
    check("aborted_sticky", aborted, 1);
    run_prog(1, 1'b0, 0, nx, fk, lk, dk);
    check("rerun_xfer", nx, 4);
    check("rerun_aborted_clr", aborted, 0);
    check("rerun_round_cnt", round_cnt, 1);
    end_run();

    // Async reset mid-run
    @(negedge clk);
    num_rounds   = 16'd5;
    run_trig     = 1'b1;
    instr_tready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_run_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_outputs", {instr_tvalid, instr_tlast, busy, run_done, aborted, err_ovf, ld_tready}, 0);
    check("arst_counts", {round_cnt, prog_len}, 0);
    check("arst_tdata", instr_tdata, 0);
    run_trig     = 1'b0;
    instr_tready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_release_ld_tready", ld_tready, 1);
    check("arst_release_idle", {busy, run_done}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
